// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access stage: access sizes, controller
// states and big-endian byte-enable patterns.
package mem_access_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_DONE = 2'd2
  } ma_state_e;

  // Byte offset 0 lives in bits 31:24, so its enable is the MSB.
  localparam logic [3:0] BE_BYTE_0  = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: store replication and byte enables, plus load
// lane extraction with sign/zero extension. Purely combinational.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] wr_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rdata[7:0];
    case (offset)
      2'd0:    lane_byte = rdata[31:24];
      2'd1:    lane_byte = rdata[23:16];
      2'd2:    lane_byte = rdata[15:8];
      default: lane_byte = rdata[7:0];
    endcase
    lane_half = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  // Size 11 falls into the word branch; low address bits are ignored there.
  always_comb begin
    be        = BE_WORD;
    wdata     = wr_data;
    load_data = rdata;
    case (size)
      MEM_SIZE_BYTE: begin
        be        = BE_BYTE_0 >> offset;
        wdata     = {4{wr_data[7:0]}};
        load_data = {{24{sign_ext & lane_byte[7]}}, lane_byte};
      end
      MEM_SIZE_HALF: begin
        be        = offset[1] ? BE_HALF_LO : BE_HALF_HI;
        wdata     = {2{wr_data[15:0]}};
        load_data = {{16{sign_ext & lane_half[15]}}, lane_half};
      end
      default: begin
        be        = BE_WORD;
        wdata     = wr_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns a pipeline load/store into one req/ack bus
// transaction and stalls until acked. Optional timeout: MEM_BUS_TIMEOUT_EN.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_rd_en_in,
  input  logic                  mem_wr_en_in,
  input  logic [1:0]            mem_size_in,
  input  logic                  mem_sign_ext_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [31:0]           wr_data_in,
  input  logic                  pipe_en,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata,
  output logic                  stall_out,
  output logic [31:0]           load_data_out,
  output logic                  bus_error_out,
  output logic [1:0]            fsm_state
);

  // Bus handshake: bus_req rises with stable addr/we/be/wdata and holds them
  // until the first cycle bus_ack is seen high; bus_req drops the next cycle.
  // bus_rdata is sampled only in that ack cycle. Ack without req is ignored.

  ma_state_e   state;
  logic [1:0]  lat_size;
  logic        lat_sext;
  logic [1:0]  lat_off;
  logic        access;

  logic [1:0]  al_size;
  logic        al_sext;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign access    = mem_rd_en_in | mem_wr_en_in;
  assign stall_out = (state == MA_REQ) || ((state == MA_IDLE) && access);
  assign fsm_state = state;

  // Live inputs steer the store lanes in IDLE; latched ones steer load extraction.
  assign al_size = (state == MA_IDLE) ? mem_size_in     : lat_size;
  assign al_sext = (state == MA_IDLE) ? mem_sign_ext_in : lat_sext;
  assign al_off  = (state == MA_IDLE) ? addr_in[1:0]    : lat_off;

  mem_lane_align u_align (
    .size      (al_size),
    .sign_ext  (al_sext),
    .offset    (al_off),
    .wr_data   (wr_data_in),
    .rdata     (bus_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (al_load)
  );

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
  logic            bus_error_q;
  assign bus_error_out = bus_error_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign bus_error_out  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= MA_IDLE;
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_be        <= '0;
      bus_wdata     <= '0;
      load_data_out <= '0;
      lat_size      <= MEM_SIZE_BYTE;
      lat_sext      <= 1'b0;
      lat_off       <= 2'd0;
`ifdef MEM_BUS_TIMEOUT_EN
      to_cnt        <= '0;
      bus_error_q   <= 1'b0;
`endif
    end else begin
      case (state)
        MA_IDLE: begin
          if (access) begin
            state     <= MA_REQ;
            bus_req   <= 1'b1;
            bus_we    <= mem_wr_en_in;
            bus_addr  <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
            bus_be    <= al_be;
            bus_wdata <= al_wdata;
            lat_size  <= mem_size_in;
            lat_sext  <= mem_sign_ext_in;
            lat_off   <= addr_in[1:0];
`ifdef MEM_BUS_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        MA_REQ: begin
          if (bus_ack) begin
            state   <= MA_DONE;
            bus_req <= 1'b0;
            if (!bus_we) load_data_out <= al_load;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          // Ack beats expiry when both land in the same cycle.
          else if (to_cnt == TO_LAST) begin
            state         <= MA_DONE;
            bus_req       <= 1'b0;
            load_data_out <= '0;
            bus_error_q   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        MA_DONE: begin
          if (pipe_en) begin
            state <= MA_IDLE;
`ifdef MEM_BUS_TIMEOUT_EN
            bus_error_q <= 1'b0;
`endif
          end
        end
        default: state <= MA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a queue-based scoreboard; the
// timeout vectors are included when MEM_BUS_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd_en_in = 1'b0;
  logic        mem_wr_en_in = 1'b0;
  logic [1:0]  mem_size_in = 2'b00;
  logic        mem_sign_ext_in = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] wr_data_in = '0;
  logic        pipe_en = 1'b1;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        bus_error_out;
  logic [1:0]  fsm_state;

  int tests = 0;
  int fails = 0;

  logic [68:0] bus_q[$];   // {we, addr, be, wdata}
  logic [32:0] res_q[$];   // {error, load_data}
  logic [1:0]  prev_state = 2'd0;

  mem_access_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd_en_in(mem_rd_en_in), .mem_wr_en_in(mem_wr_en_in),
    .mem_size_in(mem_size_in), .mem_sign_ext_in(mem_sign_ext_in),
    .addr_in(addr_in), .wr_data_in(wr_data_in), .pipe_en(pipe_en),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stall_out(stall_out), .load_data_out(load_data_out),
    .bus_error_out(bus_error_out), .fsm_state(fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: checks bus fields every REQ cycle, pops on ack, and
  // checks the result on every entry into DONE.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_req) begin
        if (bus_q.size() == 0) chk("bus_unexpected", 1, 0);
        else begin
          chk("bus_fields", {bus_we, bus_addr, bus_be, bus_wdata}, bus_q[0]);
          if (bus_ack) void'(bus_q.pop_front());
        end
      end
      if (fsm_state == MA_DONE && prev_state != MA_DONE) begin
        if (res_q.size() == 0) chk("res_unexpected", 1, 0);
        else chk("result", {bus_error_out, load_data_out}, res_q.pop_front());
      end
    end
    prev_state = rst_n ? fsm_state : 2'd0;
  end

  // Driver: issues one access, plays the bus slave, and checks stall/hold timing.
  task automatic access(input logic rd, input logic wr, input logic [1:0] size,
                        input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int waits, input bit give_ack,
                        input int hold, input logic [68:0] exp_bus,
                        input logic [32:0] exp_res, input int exp_stall);
    int  n;
    int  stalls;
    bit  done;
    @(posedge clk); #1;
    mem_rd_en_in = rd; mem_wr_en_in = wr; mem_size_in = size;
    mem_sign_ext_in = sext; addr_in = addr; wr_data_in = wdata;
    pipe_en = (hold == 0); bus_ack = 1'b0; bus_rdata = ~rdata;
    bus_q.push_back(exp_bus);
    res_q.push_back(exp_res);
    stalls = 0; n = 0; done = 0;
    @(negedge clk);
    if (stall_out) stalls++;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      bus_ack   = give_ack && (n == waits);
      bus_rdata = bus_ack ? rdata : ~rdata;
      n++;
      @(negedge clk);
      if (fsm_state == MA_DONE) done = 1;
      else if (stall_out) stalls++;
    end
    if (!done) chk("done_timeout", 0, 1);
    chk("stall_cycles", stalls, exp_stall);
    chk("done_req_low", bus_req, 0);
    chk("done_stall_low", stall_out, 0);
    if (!give_ack) bus_q.delete();
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("hold_state", fsm_state, MA_DONE);
        chk("hold_stall", stall_out, 0);
        chk("hold_load", load_data_out, exp_res[31:0]);
      end
      @(posedge clk); #1;
      bus_ack = 1'b0; pipe_en = 1'b1;
      @(negedge clk);
      chk("hold_last_state", fsm_state, MA_DONE);
    end
    @(posedge clk); #1;
    mem_rd_en_in = 1'b0; mem_wr_en_in = 1'b0; bus_ack = 1'b0; pipe_en = 1'b1;
    @(negedge clk);
    chk("back_idle", fsm_state, MA_IDLE);
    chk("error_cleared", bus_error_out, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, bus_req, 0);
    chk({tag, "_we"}, bus_we, 0);
    chk({tag, "_addr"}, bus_addr, 0);
    chk({tag, "_be"}, bus_be, 0);
    chk({tag, "_wdata"}, bus_wdata, 0);
    chk({tag, "_load"}, load_data_out, 0);
    chk({tag, "_err"}, bus_error_out, 0);
    chk({tag, "_state"}, fsm_state, MA_IDLE);
    chk({tag, "_stall"}, stall_out, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // Word store, 2 wait states
    access(0, 1, MEM_SIZE_WORD, 0, 32'h104, 32'hDEADBEEF, 32'h0, 2, 1, 0,
           {1'b1, 32'h104, 4'b1111, 32'hDEADBEEF}, {1'b0, 32'h0}, 4);

    // Stray ack with no request must be ignored
    @(posedge clk); #1; bus_ack = 1'b1; bus_rdata = 32'h55555555;
    @(negedge clk); chk("stray_ack_state", fsm_state, MA_IDLE);
    chk("stray_ack_req", bus_req, 0);
    @(posedge clk); #1; bus_ack = 1'b0;

    // Byte loads, signed and unsigned
    access(1, 0, MEM_SIZE_BYTE, 1, 32'h203, 32'h0, 32'h123456F0, 0, 1, 0,
           {1'b0, 32'h200, 4'b0001, 32'h0}, {1'b0, 32'hFFFFFFF0}, 2);
    access(1, 0, MEM_SIZE_BYTE, 0, 32'h203, 32'h0, 32'h123456F0, 0, 1, 0,
           {1'b0, 32'h200, 4'b0001, 32'h0}, {1'b0, 32'h000000F0}, 2);
    // Half store leaves load_data_out alone
    access(0, 1, MEM_SIZE_HALF, 0, 32'h302, 32'h0000ABCD, 32'h0, 1, 1, 0,
           {1'b1, 32'h300, 4'b0011, 32'hABCDABCD}, {1'b0, 32'h000000F0}, 3);
    // Signed half load held in DONE for 3 cycles
    access(1, 0, MEM_SIZE_HALF, 1, 32'h300, 32'h0, 32'h80011234, 0, 1, 3,
           {1'b0, 32'h300, 4'b1100, 32'h0}, {1'b0, 32'hFFFF8001}, 2);
    // Read and write both requested: store wins
    access(1, 1, MEM_SIZE_BYTE, 0, 32'h401, 32'h0000005A, 32'h0, 0, 1, 0,
           {1'b1, 32'h400, 4'b0100, 32'h5A5A5A5A}, {1'b0, 32'hFFFF8001}, 2);
    access(1, 0, MEM_SIZE_BYTE, 0, 32'h0, 32'h0, 32'h80FFFFFF, 0, 1, 0,
           {1'b0, 32'h0, 4'b1000, 32'h0}, {1'b0, 32'h00000080}, 2);
    // Size 11 treated as word; unaligned address forced aligned
    access(1, 0, 2'b11, 1, 32'h7, 32'h0, 32'hCAFEF00D, 1, 1, 0,
           {1'b0, 32'h4, 4'b1111, 32'h0}, {1'b0, 32'hCAFEF00D}, 3);
    access(1, 0, MEM_SIZE_HALF, 1, 32'h2, 32'h0, 32'h1234FEDC, 0, 1, 0,
           {1'b0, 32'h0, 4'b0011, 32'h0}, {1'b0, 32'hFFFFFEDC}, 2);
    access(1, 0, MEM_SIZE_HALF, 0, 32'h2, 32'h0, 32'h1234FEDC, 0, 1, 0,
           {1'b0, 32'h0, 4'b0011, 32'h0}, {1'b0, 32'h0000FEDC}, 2);
    access(0, 1, MEM_SIZE_BYTE, 0, 32'h602, 32'h123456C3, 32'h0, 0, 1, 0,
           {1'b1, 32'h600, 4'b0010, 32'hC3C3C3C3}, {1'b0, 32'h0000FEDC}, 2);

    // Reset while waiting in REQ
    @(posedge clk); #1;
    mem_rd_en_in = 1'b1; mem_size_in = MEM_SIZE_BYTE; addr_in = 32'h500;
    mem_sign_ext_in = 1'b0; wr_data_in = 32'h0;
    bus_q.push_back({1'b0, 32'h500, 4'b1000, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_req", bus_req, 1);
    rst_n = 1'b0; mem_rd_en_in = 1'b0;
    #1;
    chk_all_zero("midreset");
    bus_q.delete();
    @(negedge clk); rst_n = 1'b1;

    access(1, 0, MEM_SIZE_BYTE, 1, 32'h11, 32'h0, 32'h00AB0000, 0, 1, 0,
           {1'b0, 32'h10, 4'b0100, 32'h0}, {1'b0, 32'hFFFFFFAB}, 2);

`ifdef MEM_BUS_TIMEOUT_EN
    // No ack: abort after 4 REQ cycles with error and zeroed load data
    access(1, 0, MEM_SIZE_WORD, 0, 32'h20, 32'h0, 32'h0, 0, 0, 0,
           {1'b0, 32'h20, 4'b1111, 32'h0}, {1'b1, 32'h0}, 5);
    // Ack on the 4th REQ cycle beats expiry
    access(1, 0, MEM_SIZE_WORD, 0, 32'h24, 32'h0, 32'h11223344, 3, 1, 0,
           {1'b0, 32'h24, 4'b1111, 32'h0}, {1'b0, 32'h11223344}, 5);
`else
    // Without the timeout a long wait simply completes
    access(1, 0, MEM_SIZE_WORD, 0, 32'h24, 32'h0, 32'h11223344, 6, 1, 0,
           {1'b0, 32'h24, 4'b1111, 32'h0}, {1'b0, 32'h11223344}, 8);
`endif

    repeat (2) @(posedge clk);
    chk("bus_q_drained", bus_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
